// File: rtl/image_rto_core_if.sv
// Bridge-side push bus for image_rto_core: write strobe and entry in, full/empty status out.
interface image_rto_core_if #(
  parameter int DATA_WIDTH = 128
);
  logic                  rto_core_write;
  logic [DATA_WIDTH-1:0] rto_core_fifo_din;
  logic                  rto_core_full;
  logic                  rto_core_empty;

  modport master (output rto_core_write, rto_core_fifo_din, input rto_core_full, rto_core_empty);
  modport slave  (input rto_core_write, rto_core_fifo_din, output rto_core_full, rto_core_empty);
endinterface

// File: rtl/image_rto_core.sv
// Timed command consumer: buffers {ts, payload} entries and strobes each payload once counter >= ts.
// Define IMAGE_RTO_LATE_DROP_EN to discard (rather than release) entries that arrive late.
module image_rto_core #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH      = 128
) (
  input  logic                     rtio_clk,
  input  logic                     resetn,
  input  logic                     rto_core_reset,
  input  logic                     rto_core_flush,
  image_rto_core_if.slave          bridge,
  input  logic                     auto_start,
  input  logic [63:0]              counter,
  output logic                     image_cmd_valid,
  output logic [DATA_WIDTH-64-1:0] image_cmd_data,
  output logic                     late_error,
  output logic                     overflow_error,
  output logic [31:0]              fired_count
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = DATA_WIDTH - 64;

  typedef logic [FIFO_DEPTH_LOG2-1:0] ptr_t;
  typedef logic [FIFO_DEPTH_LOG2:0]   cnt_t;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  ptr_t                  wr_ptr_q, rd_ptr_q;
  cnt_t                  count_q, count_d;
  logic                  full_q, empty_q;
  state_e                state_q, state_d;
  logic [63:0]           ts_q;
  logic [PW-1:0]         pl_q, data_q;
  logic                  first_q, valid_q, late_q, ovf_q;
  logic [31:0]           fired_q;
  logic                  rst, push, pop, fire, late_now, drop, rel;

  assign rst      = !resetn || rto_core_reset;
  assign push     = bridge.rto_core_write && !full_q && !rto_core_flush;
  assign late_now = (state_q == S_WAIT) && first_q && (counter > ts_q);
  assign rel      = fire && !drop;

`ifdef IMAGE_RTO_LATE_DROP_EN
  // Lateness is only judged on the first WAIT cycle; remember it across an auto_start freeze.
  logic head_late_q;
  assign drop = late_now || head_late_q;

  always_ff @(posedge rtio_clk) begin
    if (rst)                    head_late_q <= 1'b0;
    else if (state_q == S_LOAD) head_late_q <= 1'b0;
    else if (late_now)          head_late_q <= 1'b1;
  end
`else
  assign drop = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      S_IDLE: if (auto_start && !empty_q) begin
        pop     = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: state_d = S_WAIT;
      S_WAIT: if (auto_start && counter >= ts_q) begin
        fire = 1'b1;
        if (!empty_q) begin
          pop     = 1'b1;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush discards the head and suppresses any release due this cycle.
    if (rto_core_flush) begin
      state_d = S_IDLE;
      pop     = 1'b0;
      fire    = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge rtio_clk) begin
    if (push) mem_q[wr_ptr_q] <= bridge.rto_core_fifo_din;
  end

  always_ff @(posedge rtio_clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ts_q     <= '0;
      pl_q     <= '0;
      first_q  <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      late_q   <= 1'b0;
      ovf_q    <= 1'b0;
      fired_q  <= '0;
    end else begin
      state_q <= state_d;
      if (rto_core_flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        full_q   <= 1'b0;
        empty_q  <= 1'b1;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_d;
        full_q  <= (count_d == cnt_t'(DEPTH));
        empty_q <= (count_d == '0);
      end
      if (pop) {ts_q, pl_q} <= mem_q[rd_ptr_q];
      first_q <= (state_q == S_LOAD) && !rto_core_flush;
      if (late_now) late_q <= 1'b1;
      if (bridge.rto_core_write && full_q && !rto_core_flush) ovf_q <= 1'b1;
      valid_q <= rel;
      if (rel) begin
        data_q  <= pl_q;
        fired_q <= fired_q + 32'd1;
      end
    end
  end

  assign bridge.rto_core_full  = full_q;
  assign bridge.rto_core_empty = empty_q;
  assign image_cmd_valid       = valid_q;
  assign image_cmd_data        = data_q;
  assign late_error            = late_q;
  assign overflow_error        = ovf_q;
  assign fired_count           = fired_q;
endmodule

// File: tb/tb_image_rto_core.sv
// Self-checking bench for image_rto_core: vector table, directed corner sequences, randomized schedules.
module tb_image_rto_core;
  localparam int DW = 128;
`ifdef IMAGE_RTO_LATE_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn, rto_core_reset, rto_core_flush, auto_start;
  logic [63:0] counter;
  logic        image_cmd_valid;
  logic [63:0] image_cmd_data;
  logic        late_error, overflow_error;
  logic [31:0] fired_count;

  image_rto_core_if #(.DATA_WIDTH(DW)) bus ();

  image_rto_core #(.FIFO_DEPTH_LOG2(4), .DATA_WIDTH(DW)) dut (
    .rtio_clk        (clk),
    .resetn          (resetn),
    .rto_core_reset  (rto_core_reset),
    .rto_core_flush  (rto_core_flush),
    .bridge          (bus),
    .auto_start      (auto_start),
    .counter         (counter),
    .image_cmd_valid (image_cmd_valid),
    .image_cmd_data  (image_cmd_data),
    .late_error      (late_error),
    .overflow_error  (overflow_error),
    .fired_count     (fired_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  bit          run;
  int          obs_cyc[$];
  logic [63:0] obs_dat[$];
  logic [63:0] obs_cnt[$];

  typedef struct {
    logic [63:0] ts;
    logic [63:0] start;
    bit          run;
    logic [63:0] pl;
    int          rel;
    bit          late;
  } vec_t;
  vec_t tbl[8];

  int          sp[$];
  int          sts[$];
  logic [63:0] spl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycle index cyc and the counter value describe the cycle just entered.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (run) counter = counter + 64'd1;
    if (image_cmd_valid) begin
      obs_cyc.push_back(cyc);
      obs_dat.push_back(image_cmd_data);
      obs_cnt.push_back(counter);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; rto_core_reset = 1'b0; rto_core_flush = 1'b0; auto_start = 1'b0;
    bus.rto_core_write = 1'b0; bus.rto_core_fifo_din = '0;
    counter = '0; run = 1'b0;
    step(); step();
    resetn = 1'b1;
    obs_cyc.delete(); obs_dat.delete(); obs_cnt.delete();
    cyc = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " valid"}, 64'(image_cmd_valid), 64'd0);
    chk({tag, " data"}, image_cmd_data, 64'd0);
    chk({tag, " late"}, 64'(late_error), 64'd0);
    chk({tag, " ovf"}, 64'(overflow_error), 64'd0);
    chk({tag, " fired"}, 64'(fired_count), 64'd0);
    chk({tag, " empty"}, 64'(bus.rto_core_empty), 64'd1);
    chk({tag, " full"}, 64'(bus.rto_core_full), 64'd0);
  endtask

  // Schedule model: counter == cycle index; an entry is popped as soon as it is buffered and the
  // previous entry has fired, reaches WAIT two cycles after the pop, fires at max(WAIT, ts).
  task automatic run_sched(input string tag);
    int          exp_cyc[$];
    logic [63:0] exp_pl[$];
    bit          any_late;
    int          fprev, pop_c, w, f, last, k;
    bit          late;
    any_late = 1'b0; fprev = -1000; last = 0;
    for (int i = 0; i < sp.size(); i++) begin
      pop_c = (sp[i] + 1 > fprev) ? sp[i] + 1 : fprev;
      w     = pop_c + 2;
      late  = w > sts[i];
      f     = (w > sts[i]) ? w : sts[i];
      fprev = f;
      last  = f + 1;
      any_late |= late;
      if (!(DROP && late)) begin
        exp_cyc.push_back(f + 1);
        exp_pl.push_back(spl[i]);
      end
    end
    k = 0;
    while (cyc <= last + 4) begin
      if (k < sp.size() && cyc == sp[k]) begin
        bus.rto_core_write = 1'b1;
        bus.rto_core_fifo_din = {64'(sts[k]), spl[k]};
        k++;
      end else begin
        bus.rto_core_write = 1'b0;
      end
      step();
    end
    bus.rto_core_write = 1'b0;
    chk({tag, " strobes"}, 64'(obs_cyc.size()), 64'(exp_cyc.size()));
    for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
      chk($sformatf("%s strobe%0d cyc", tag, i), 64'(obs_cyc[i]), 64'(exp_cyc[i]));
      chk($sformatf("%s strobe%0d data", tag, i), obs_dat[i], exp_pl[i]);
    end
    chk({tag, " fired"}, 64'(fired_count), 64'(exp_cyc.size()));
    chk({tag, " late"}, 64'(late_error), 64'(any_late));
  endtask

  initial begin
    int  p;
    int  t;
    bit  exp_fire;

    tbl[0] = '{ts: 64'd100, start: 64'd0, run: 1'b1, pl: 64'hA5, rel: 101, late: 1'b0};
    tbl[1] = '{ts: 64'd0, start: 64'd0, run: 1'b0, pl: 64'h1234, rel: 4, late: 1'b0};
    tbl[2] = '{ts: 64'd5, start: 64'd50, run: 1'b1, pl: 64'h55, rel: 4, late: 1'b1};
    tbl[3] = '{ts: 64'd53, start: 64'd50, run: 1'b1, pl: 64'h53, rel: 4, late: 1'b0};
    tbl[4] = '{ts: 64'd52, start: 64'd50, run: 1'b1, pl: 64'h52, rel: 4, late: 1'b1};
    tbl[5] = '{ts: 64'd54, start: 64'd50, run: 1'b1, pl: 64'h54, rel: 5, late: 1'b0};
    tbl[6] = '{ts: 64'h8000_0000_0000_0000, start: 64'h7FFF_FFFF_FFFF_FFF0, run: 1'b1,
               pl: 64'hDEAD_BEEF_0000_0001, rel: 17, late: 1'b0};
    tbl[7] = '{ts: 64'hFFFF_FFFF_FFFF_FFFF, start: 64'hFFFF_FFFF_FFFF_FFF0, run: 1'b1,
               pl: 64'hFFFF_0000_FFFF_0000, rel: 16, late: 1'b0};

    do_reset();
    chk_reset("por");

    // Single-entry vectors
    for (int i = 0; i < 8; i++) begin
      do_reset();
      counter = tbl[i].start; run = tbl[i].run; auto_start = 1'b1;
      bus.rto_core_write = 1'b1; bus.rto_core_fifo_din = {tbl[i].ts, tbl[i].pl};
      step();
      bus.rto_core_write = 1'b0;
      while (cyc < tbl[i].rel + 8) step();
      exp_fire = !(DROP && tbl[i].late);
      chk($sformatf("vec%0d strobes", i), 64'(obs_cyc.size()), exp_fire ? 64'd1 : 64'd0);
      if (exp_fire) begin
        chk($sformatf("vec%0d strobe_cyc", i), (obs_cyc.size() > 0) ? 64'(obs_cyc[0]) : 64'hFFFF, 64'(tbl[i].rel));
        chk($sformatf("vec%0d data", i), (obs_dat.size() > 0) ? obs_dat[0] : 64'hX, tbl[i].pl);
      end
      chk($sformatf("vec%0d late", i), 64'(late_error), 64'(tbl[i].late));
      chk($sformatf("vec%0d fired", i), 64'(fired_count), exp_fire ? 64'd1 : 64'd0);
    end

    // Colliding timestamps 10,11,12
    do_reset();
    run = 1'b1; auto_start = 1'b1;
    sp = '{0, 1, 2}; sts = '{10, 11, 12}; spl = '{64'h10, 64'h11, 64'h12};
    run_sched("collide");

    // Fill to full, overflow, then drain in order
    do_reset();
    counter = 64'd1000;
    for (int i = 0; i < 17; i++) begin
      bus.rto_core_write = 1'b1; bus.rto_core_fifo_din = {64'd1000, 64'(i)};
      step();
      if (i == 15) begin
        chk("fill full", 64'(bus.rto_core_full), 64'd1);
        chk("fill no ovf yet", 64'(overflow_error), 64'd0);
      end
    end
    bus.rto_core_write = 1'b0;
    chk("ovf set", 64'(overflow_error), 64'd1);
    chk("ovf full", 64'(bus.rto_core_full), 64'd1);
    auto_start = 1'b1;
    for (int g = 0; g < 50; g++) step();
    chk("drain strobes", 64'(obs_cyc.size()), 64'd16);
    for (int j = 0; j < obs_cyc.size(); j++) begin
      chk($sformatf("drain%0d data", j), obs_dat[j], 64'(j));
      if (j > 0) chk($sformatf("drain%0d gap", j), 64'(obs_cyc[j] - obs_cyc[j-1]), 64'd2);
    end
    chk("drain fired", 64'(fired_count), 64'd16);
    chk("drain empty", 64'(bus.rto_core_empty), 64'd1);

    // Flush with a waiting head and three buffered entries; sticky state must survive
    obs_cyc.delete(); obs_dat.delete(); obs_cnt.delete();
    counter = 64'd495; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.rto_core_write = 1'b1; bus.rto_core_fifo_din = {64'(1000 + i), 64'(100 + i)};
      step();
    end
    bus.rto_core_write = 1'b0;
    for (int g = 0; g < 20 && counter != 64'd500; g++) step();
    chk("flush at 500", counter, 64'd500);
    rto_core_flush = 1'b1;
    bus.rto_core_write = 1'b1; bus.rto_core_fifo_din = {64'd1005, 64'hEE};
    step();
    rto_core_flush = 1'b0; bus.rto_core_write = 1'b0;
    chk("flush empty", 64'(bus.rto_core_empty), 64'd1);
    step();
    chk("flush push dropped", 64'(bus.rto_core_empty), 64'd1);
    counter = 64'd995;
    for (int g = 0; g < 25; g++) step();
    chk("flush strobes", 64'(obs_cyc.size()), 64'd0);
    chk("flush ovf kept", 64'(overflow_error), 64'd1);
    chk("flush fired kept", 64'(fired_count), 64'd16);
    chk("flush no late", 64'(late_error), 64'd0);

    // Freeze mid-WAIT, release after re-enable, then soft reset
    do_reset();
    run = 1'b1; auto_start = 1'b1;
    bus.rto_core_write = 1'b1; bus.rto_core_fifo_din = {64'd30, 64'h77};
    step();
    bus.rto_core_write = 1'b0;
    for (int g = 0; g < 100 && counter != 64'd28; g++) step();
    auto_start = 1'b0;
    for (int g = 0; g < 100 && counter != 64'd50; g++) step();
    chk("freeze no early", 64'(obs_cyc.size()), 64'd0);
    auto_start = 1'b1;
    for (int g = 0; g < 5; g++) step();
    chk("freeze strobes", 64'(obs_cyc.size()), 64'd1);
    chk("freeze strobe cnt", (obs_cnt.size() > 0) ? obs_cnt[0] : 64'hFFFF, 64'd51);
    chk("freeze data", image_cmd_data, 64'h77);
    chk("freeze late", 64'(late_error), 64'd0);
    chk("freeze fired", 64'(fired_count), 64'd1);
    rto_core_reset = 1'b1;
    step();
    rto_core_reset = 1'b0;
    chk_reset("softrst");

    // Randomized schedules
    for (int it = 0; it < 4; it++) begin
      do_reset();
      run = 1'b1; auto_start = 1'b1;
      sp.delete(); sts.delete(); spl.delete();
      p = int'($urandom_range(0, 5));
      for (int i = 0; i < 10; i++) begin
        t = p + int'($urandom_range(0, 30)) - 4;
        if (t < 0) t = 0;
        sp.push_back(p);
        sts.push_back(t);
        spl.push_back({$urandom, $urandom});
        p += int'($urandom_range(1, 15));
      end
      run_sched($sformatf("rand%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/image_rto_core.md
Name: image_rto_core

Overview:
- Timed command consumer that sits directly downstream of the AXI-to-FIFO bridge in the rtio_clk domain.
- Buffers 128-bit entries pushed by the bridge. Each entry is {timestamp[127:64], payload[63:0]}.
- Releases each payload to the image display pipeline as a one-cycle strobe once the global 64-bit time counter reaches the entry's timestamp.
- Reports full/empty back to the bridge and raises sticky late/overflow flags.

Parameters:
- FIFO_DEPTH_LOG2, 4, log2 of internal entry buffer depth (16 entries).
- DATA_WIDTH, 128, entry width; upper 64 bits are timestamp, lower DATA_WIDTH-64 bits are payload.

Ports:
- rtio_clk  in  1  single clock; all logic is on its rising edge.
- resetn  in  1  synchronous, active-low reset.
- rto_core_reset  in  1  soft reset pulse: same effect as resetn.
- rto_core_flush  in  1  discard buffered and pending entries; keep sticky flags.
- rto_core_write  in  1  push strobe from bridge.
- rto_core_fifo_din  in  DATA_WIDTH  pushed entry.
- rto_core_full  out  1  buffer holds FIFO_DEPTH entries.
- rto_core_empty  out  1  buffer holds 0 entries.
- auto_start  in  1  run enable (level).
- counter  in  64  global time counter, unsigned.
- image_cmd_valid  out  1  one-cycle release strobe.
- image_cmd_data  out  DATA_WIDTH-64  released payload, held until next release.
- late_error  out  1  sticky: an entry was loaded after its timestamp.
- overflow_error  out  1  sticky: a push arrived while full.
- fired_count  out  32  number of releases since reset, wraps at 2^32.

Behaviour:
- Reset (resetn low or rto_core_reset high, sampled at edge):
  - buffer emptied; state IDLE.
  - image_cmd_valid=0, image_cmd_data=0, late_error=0, overflow_error=0, fired_count=0.
  - rto_core_empty=1, rto_core_full=0.
  - resetn has priority over everything else.
- Buffer:
  - Circular, FIFO_DEPTH entries, with FIFO_DEPTH_LOG2+1-bit occupancy count.
  - A push is accepted iff rto_core_write=1 and full=0 at the start of the cycle.
  - A push while full is dropped and sets overflow_error.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - Status flags are registered: a push into an empty buffer deasserts rto_core_empty on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- State machine, states IDLE, LOAD, WAIT:
  - IDLE: if auto_start=1 and empty=0, pop head and go to LOAD.
  - LOAD: latch popped entry into the head register (timestamp ts, payload pl), then go to WAIT.
  - WAIT, first cycle: if counter > ts (strictly greater), set late_error. The entry is still released (see optional feature).
  - WAIT: if auto_start=0, freeze; hold the head and do not release.
  - WAIT: if auto_start=1 and counter >= ts:
    - next cycle: image_cmd_valid=1, image_cmd_data=pl, fired_count+1;
    - if auto_start=1 and empty=0, pop the next entry and go to LOAD; otherwise go to IDLE.
- Timing:
  - Release strobe is exactly one cycle, registered, asserted the cycle after the first cycle with counter >= ts.
  - Minimum spacing between strobes is 2 cycles.
  - Latency from push into an empty idle buffer to WAIT is 3 cycles: empty deasserts, pop, LOAD.
- Flush:
  - rto_core_flush=1 empties the buffer, discards the head and returns to IDLE.
  - No strobe is issued in that cycle, even if a release was due.
  - Flush wins over a same-cycle push; the push is dropped without setting overflow.
  - Sticky flags and fired_count are unchanged.
- Arithmetic:
  - All timestamp comparisons are 64-bit unsigned.
  - Timestamp 0 releases immediately.

Optional Feature:
- Macro IMAGE_RTO_LATE_DROP_EN.
- Defined: a late entry (counter > ts on first WAIT cycle) is discarded. There is no strobe and no fired_count increment, late_error is still set, and the FSM proceeds as if released.
- Undefined: late entries are released immediately as described above.

Test Plan:
- Push {ts=100, pl=0xA5} with counter running from 0 and auto_start=1 -> exactly one image_cmd_valid pulse, in the cycle after counter=100; image_cmd_data=0xA5; fired_count=1; late_error=0.
- Push ts=10,11,12 at counter=0 -> three strobes; spacing is 2 cycles where timestamps collide, otherwise aligned to counter+1; fired_count=3.
- Push 17 entries with auto_start=0 -> rto_core_full=1 after 16 pushes; 17th dropped; overflow_error=1; then auto_start=1 -> exactly 16 releases in order.
- Push ts=5 at counter=50 -> late_error=1. Macro undefined: strobe at first WAIT+1. Macro defined: no strobe and fired_count=0.
- Head waiting on ts=1000, buffer holding 3 entries, assert rto_core_flush at counter=500 -> no strobes ever; rto_core_empty=1 next cycle; sticky flags kept.
- Mid-WAIT: drop auto_start at counter=ts-2 and raise it at ts+20 -> strobe in the cycle after re-enable, no earlier. Then pulse rto_core_reset -> all outputs return to reset values.
